// File: rtl/sop_vector_checker.sv
// rtl/sop_vector_checker.sv - exhaustive 3-input SOP response checker; optional early abort via SOP_CHK_STOP_ON_FAIL_EN
module sop_vector_checker #(
  parameter logic [7:0] TRUTH_TABLE   = 8'h8A,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         PASSES        = 1,
  parameter int         CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic             f_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  // Counter widths never drop below one bit so single-cycle settle / single pass still elaborate.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [2:0]      vec;
  logic [SW-1:0]   settle_cnt;
  logic [PW-1:0]   pass_cnt;
  logic            mismatch;
  logic            settle_done;
  logic            last_vec;
  logic            advance;

  // The stimulus is the vector register itself, so x,y,z only move when vec is reloaded.
  assign x = vec[2];
  assign y = vec[1];
  assign z = vec[0];

  // Case-inequality so an undriven or X response from the unit under check counts as a failure.
  always_comb begin
    mismatch    = (f_in !== TRUTH_TABLE[vec]);
    settle_done = (settle_cnt == SETTLE_LAST);
    last_vec    = (vec == 3'd7) && (pass_cnt == PASS_LAST);
    advance     = (state == SAMPLE) && (state_next == SETTLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one SETTLE window per vector followed by a single SAMPLE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_done) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (last_vec) begin
          state_next = FINISH;
        end else begin
          state_next = SETTLE;
        end
`ifdef SOP_CHK_STOP_ON_FAIL_EN
        if (mismatch) begin
          state_next = FINISH;
        end
`endif
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Vector sequencing, error accounting and the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec              <= 3'd0;
      settle_cnt       <= '0;
      pass_cnt         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= 3'd0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec              <= 3'd0;
            settle_cnt       <= '0;
            pass_cnt         <= '0;
            busy             <= 1'b1;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
          end
        end
        SETTLE: begin
          if (!settle_done) begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) begin
              err_count <= err_count + CNT_W'(1);
            end
            if (!first_fail_valid) begin
              first_fail_vec   <= vec;
              first_fail_valid <= 1'b1;
            end
          end
          if (advance) begin
            vec        <= vec + 3'd1;
            settle_cnt <= '0;
            if (vec == 3'd7) begin
              pass_cnt <= pass_cnt + PW'(1);
            end
          end
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (err_count == '0);
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
